// File: rtl/grant_ctrl.sv
// Single-owner grant controller: latches the encoded winner, holds its grant
// until that requester strobes done or the hold limit expires, then releases.
module grant_ctrl #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] code_in,
  input  logic       valid_in,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout,
  output logic [7:0] grant_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_d;
  logic [1:0] owner, owner_d;
  logic [7:0] hold, hold_d;
  logic [3:0] grant_d;
  logic       busy_d, timeout_d;
  logic [7:0] cnt_d;

  // Outputs are computed here as next-state values and registered below, so
  // every output changes only on a clock edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state;
    owner_d   = owner;
    hold_d    = hold;
    grant_d   = grant;
    timeout_d = 1'b0;
    cnt_d     = grant_cnt;

    unique case (state)
      IDLE: begin
        grant_d = '0;
        hold_d  = '0;
        if (valid_in) begin
          state_d = GRANT;
          owner_d = code_in;
          grant_d = 4'(1) << code_in;
        end
      end
      GRANT: begin
        // done of the owner wins over an expiring hold counter
        if (done[owner]) begin
          state_d = RELEASE;
          grant_d = '0;
          if (grant_cnt != 8'hFF) cnt_d = grant_cnt + 8'd1;
        end else if (hold == HOLD_LAST) begin
          state_d   = RELEASE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold + 8'd1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      hold      <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      grant_cnt <= '0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      hold      <= hold_d;
      grant     <= grant_d;
      busy      <= busy_d;
      timeout   <= timeout_d;
      grant_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_grant_ctrl.sv
// Self-checking bench for grant_ctrl: directed scenarios plus random traffic,
// all compared every cycle against a behavioural grant/age/release model.
module tb_grant_ctrl;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] code_in;
  logic       valid_in;
  logic [3:0] done;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;
  logic [7:0] grant_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  // behavioural model: who holds the grant, for how long, and pending release
  bit m_holding, m_releasing, m_timeout;
  int m_owner, m_age, m_cnt;

  // per-scenario observation counters
  int obs_grant_cycles, obs_timeouts;

  grant_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .valid_in(valid_in), .done(done),
    .grant(grant), .busy(busy), .timeout(timeout), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_holding = 0; m_releasing = 0; m_timeout = 0; m_owner = 0; m_age = 0; m_cnt = 0;
    end else if (m_releasing) begin
      m_releasing = 0; m_timeout = 0;
    end else if (m_holding) begin
      m_timeout = 0;
      if (done[m_owner]) begin
        m_holding = 0; m_releasing = 1;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end else if (m_age == MAX_HOLD - 1) begin
        m_holding = 0; m_releasing = 1; m_timeout = 1;
      end else begin
        m_age++;
      end
    end else begin
      m_timeout = 0;
      if (valid_in) begin
        m_holding = 1; m_owner = int'(code_in); m_age = 0;
      end
    end
  endtask

  // one clock: model follows the edge, outputs compared 1 time unit later
  task automatic step();
    logic [3:0] exp_grant;
    @(posedge clk);
    model_edge();
    #1;
    exp_grant = m_holding ? 4'(1 << m_owner) : 4'b0000;
    check("grant", 32'(grant), 32'(exp_grant));
    check("busy", 32'(busy), 32'(m_holding | m_releasing));
    check("timeout", 32'(timeout), 32'(m_timeout));
    check("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
    check("onehot", 32'($countones(grant) <= 1), 32'(1));
    if (grant != 4'b0) obs_grant_cycles++;
    if (timeout) obs_timeouts++;
  endtask

  task automatic clear_obs();
    obs_grant_cycles = 0;
    obs_timeouts     = 0;
  endtask

  task automatic drain(input string name);
    int budget = 40;
    while (busy && budget > 0) begin
      step();
      budget--;
    end
    check({name, "_drain_bound"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int rises, zero_run, spacing_bad;
    logic [3:0] prev_grant;

    rst = 1'b1; code_in = 2'd0; valid_in = 1'b0; done = 4'b0;
    step(); step();
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_cnt", 32'(grant_cnt), 32'h0);
    rst = 1'b0;
    step();

    // basic: owner 2, done[2] arrives so the grant lasts three cycles
    clear_obs();
    valid_in = 1'b1; code_in = 2'd2;
    step();
    check("basic_first_grant", 32'(grant), 32'h4);
    valid_in = 1'b0; code_in = 2'd1;
    step(); step();
    done = 4'b0100;
    step();
    check("basic_release_grant", 32'(grant), 32'h0);
    check("basic_release_busy", 32'(busy), 32'h1);
    done = 4'b0;
    step();
    check("basic_idle_busy", 32'(busy), 32'h0);
    check("basic_cnt", 32'(grant_cnt), 32'd1);
    check("basic_grant_cycles", 32'(obs_grant_cycles), 32'd3);
    check("basic_no_timeout", 32'(obs_timeouts), 32'd0);

    // timeout: owner 3, no done -> 16 grant cycles and one timeout pulse
    clear_obs();
    valid_in = 1'b1; code_in = 2'd3;
    step();
    valid_in = 1'b0;
    drain("timeout");
    check("timeout_grant_cycles", 32'(obs_grant_cycles), 32'd16);
    check("timeout_pulses", 32'(obs_timeouts), 32'd1);
    check("timeout_cnt", 32'(grant_cnt), 32'd1);

    // tie: done[owner] on the 16th grant cycle beats the timeout
    clear_obs();
    valid_in = 1'b1; code_in = 2'd0;
    step();
    valid_in = 1'b0;
    for (int i = 0; i < 15; i++) step();
    done = 4'b0001;
    step();
    done = 4'b0;
    drain("tie");
    check("tie_grant_cycles", 32'(obs_grant_cycles), 32'd16);
    check("tie_no_timeout", 32'(obs_timeouts), 32'd0);
    check("tie_cnt", 32'(grant_cnt), 32'd2);

    // noise: owner 1 keeps the grant while other inputs toggle
    valid_in = 1'b1; code_in = 2'd1;
    step();
    for (int i = 0; i < 8; i++) begin
      done     = 4'($urandom) & 4'b1101;
      code_in  = 2'($urandom);
      valid_in = 1'($urandom);
      step();
      check("noise_grant", 32'(grant), 32'h2);
    end
    done = 4'b0010; valid_in = 1'b0;
    step();
    done = 4'b0;
    drain("noise");
    check("noise_cnt", 32'(grant_cnt), 32'd3);

    // reset on the 5th grant cycle aborts without counting or timeout
    valid_in = 1'b1; code_in = 2'd2;
    step();
    valid_in = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_cnt", 32'(grant_cnt), 32'h0);
    check("midrst_timeout", 32'(timeout), 32'h0);

    // saturation: back-to-back normal grants, each separated by two zero cycles
    valid_in = 1'b1; done = 4'hF;
    rises = 0; zero_run = 0; spacing_bad = 0; prev_grant = 4'b0;
    for (int i = 0; i < 780; i++) begin
      code_in = 2'($urandom);
      step();
      if (grant != 4'b0 && prev_grant == 4'b0) begin
        if (rises > 0 && zero_run != 2) spacing_bad++;
        rises++;
        zero_run = 0;
      end else if (grant == 4'b0) begin
        zero_run++;
      end
      prev_grant = grant;
    end
    valid_in = 1'b0; done = 4'b0;
    drain("sat");
    check("sat_grants", 32'(rises), 32'd260);
    check("sat_spacing", 32'(spacing_bad), 32'd0);
    check("sat_cnt", 32'(grant_cnt), 32'd255);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      valid_in = 1'($urandom);
      code_in  = 2'($urandom);
      for (int b = 0; b < 4; b++) done[b] = ($urandom_range(0, 9) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/grant_ctrl.md
GRANT_CTRL -- requirements
Module: grant_ctrl

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum cycles one grant is held before forced release; legal range 2..255.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: code_in  input  2  index of winning requester, from the upstream priority encoder.
REQ-005 Port: valid_in  input  1  high when code_in is meaningful (at least one request pending).
REQ-006 Port: done  input  4  per-requester release strobe; bit i meaningful only while requester i holds the grant.
REQ-007 Port: grant  output  4  one-hot grant to the owning requester; all-zero when no owner.
REQ-008 Port: busy  output  1  high in any state other than IDLE.
REQ-009 Port: timeout  output  1  single-cycle pulse when a grant is force-released.
REQ-010 Port: grant_cnt  output  8  count of grants released normally via done; saturates.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, GRANT, RELEASE; all outputs SHALL be registered.
REQ-012 In IDLE with valid_in=1 at edge N, the block SHALL latch code_in as owner, enter GRANT, and drive grant[owner]=1 from edge N (one-cycle latency).
REQ-013 In IDLE with valid_in=0, the block SHALL remain in IDLE with grant=0000; code_in SHALL be ignored.
REQ-014 On entry to GRANT, an 8-bit hold counter SHALL be 0 and SHALL increment by 1 on each edge spent in GRANT.
REQ-015 In GRANT, done[owner]=1 at an edge SHALL move the FSM to RELEASE, clear grant, and increment grant_cnt by 1 unless it is 255.
REQ-016 In GRANT, if done[owner]=0 and hold counter = MAX_HOLD-1 at an edge, the FSM SHALL move to RELEASE, clear grant, and pulse timeout high for exactly that next cycle; grant_cnt unchanged.
REQ-017 If done[owner]=1 in the same cycle as hold counter = MAX_HOLD-1, done SHALL win: normal release, no timeout pulse, grant_cnt incremented.
REQ-018 done bits of non-owners SHALL be ignored in every state.
REQ-019 Changes on valid_in and code_in during GRANT and RELEASE SHALL be ignored; the owner SHALL not change mid-grant.
REQ-020 RELEASE SHALL last exactly one cycle with grant=0000 and busy=1, then return to IDLE unconditionally; valid_in is not sampled in RELEASE.
REQ-021 The minimum spacing between two consecutive grants SHALL therefore be one all-zero grant cycle plus one IDLE cycle.
REQ-022 grant SHALL never have more than one bit set in any cycle.
REQ-023 grant_cnt SHALL hold at 255 once reached; it SHALL not wrap.

Reset
REQ-024 With rst=1 at an edge, the block SHALL enter IDLE with grant=0000, busy=0, timeout=0, grant_cnt=0, hold counter=0, owner=0.
REQ-025 Reset SHALL take priority over every other input, including mid-GRANT; an aborted grant SHALL not increment grant_cnt nor pulse timeout.
REQ-026 After rst deasserts, the first valid_in=1 sampled in IDLE SHALL be served per REQ-012.

Verification
REQ-027 Basic: reset; code_in=10, valid_in=1 one cycle; done[2]=1 three cycles later -> grant=0100 for 3 cycles, one RELEASE cycle with grant=0000, grant_cnt=1, timeout never high.
REQ-028 Timeout: MAX_HOLD=16, grant owner 3, done held 0 -> grant=1000 for exactly 16 cycles, timeout=1 for one cycle, grant_cnt unchanged.
REQ-029 Tie: done[owner]=1 on the 16th GRANT cycle (counter=15) -> normal release, timeout=0, grant_cnt incremented.
REQ-030 Noise: during a grant to owner 1, toggle done[0], done[2], done[3], code_in, valid_in -> grant stays 0010 until done[1] or timeout.
REQ-031 Reset mid-operation: rst=1 on the 5th GRANT cycle -> next cycle grant=0000, busy=0, grant_cnt=0, timeout=0.
REQ-032 Saturation: 260 back-to-back normal grants with valid_in held 1 -> grant_cnt reaches 255 and holds; each grant separated by one zero-grant cycle plus one IDLE cycle.
